argmax_classifier: RTL and testbench

- Sits directly downstream of the final softmax stage.
- Consumes the 7-class probability vector (float32 per class) and scans it serially, one class per cycle.
- Reports the winning class index, its score, and a low-confidence reject flag.
- Holds the result under a valid/ready handshake toward the result sink (UART/LED/host interface).

---
 rtl/argmax_pkg.sv | 29 ++
 rtl/argmax_classifier_cmp.sv | 43 ++++
 rtl/argmax_classifier.sv | 177 +++++++++++++++++
 tb/tb_argmax_classifier.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/argmax_pkg.sv
// -----------------------------------------------------------------------------
// argmax_pkg
// Shared constants, FSM state encoding and float32 ordering helpers for the
// argmax_classifier block and its fp32_cmp_ge comparator.
// -----------------------------------------------------------------------------
package argmax_pkg;

    localparam int          NUM_CLASS     = 7;
    localparam int          IDX_WIDHT     = 3;
    localparam logic [31:0] THRESHOLD_DEF = 32'h3F000000;  // 0.5

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_SCAN = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    function automatic logic fp32_is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    // Maps float32 bit patterns onto an unsigned total order. Both zeros map
    // to the same key so that -0 and +0 compare equal.
    function automatic logic [31:0] fp32_key(input logic [31:0] x);
        if (x[30:0] == 31'd0)
            return 32'h80000000;
        return x[31] ? ~x : (x ^ 32'h80000000);
    endfunction

endpackage

// File: rtl/argmax_classifier_cmp.sv
// -----------------------------------------------------------------------------
// fp32_cmp_ge
// Combinational float32 comparator.
//   a, b    : float32 operands (raw bits)
//   a_gt_b  : a strictly greater than b
//   a_ge_b  : a greater than or equal to b
// A NaN operand a is never greater or equal; a non-NaN a always beats a NaN b.
// -----------------------------------------------------------------------------
module fp32_cmp_ge
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        a_gt_b,
    output logic        a_ge_b
);
    import argmax_pkg::*;

    logic        a_nan;
    logic        b_nan;
    logic [31:0] key_a;
    logic [31:0] key_b;

    assign a_nan = fp32_is_nan(a);
    assign b_nan = fp32_is_nan(b);
    assign key_a = fp32_key(a);
    assign key_b = fp32_key(b);

    always_comb begin
        a_gt_b = 1'b0;
        a_ge_b = 1'b0;
        if (a_nan) begin
            a_gt_b = 1'b0;
            a_ge_b = 1'b0;
        end else if (b_nan) begin
            a_gt_b = 1'b1;
            a_ge_b = 1'b1;
        end else begin
            a_gt_b = (key_a >  key_b);
            a_ge_b = (key_a >= key_b);
        end
    end

endmodule

// File: rtl/argmax_classifier.sv
// -----------------------------------------------------------------------------
// argmax_classifier
// Serial argmax over a NUM_CLASS float32 probability vector, one class per
// cycle, with a low-confidence reject flag and a valid/ready result port.
//
// Ports:
//   clk, rst      : clock, synchronous active-low reset
//   Valid_In      : input vector valid (single-cycle pulse)
//   Ready_Out     : block can accept a vector this cycle
//   Data_In       : NUM_CLASS packed float32 scores, class k at [32k+31:32k]
//   Valid_Out     : result valid
//   Ready_In      : sink accepts result
//   Class_Out     : winning class index
//   Score_Out     : winning score (raw float32 bits)
//   Reject_Out    : winning score below THRESHOLD (or NaN)
//   Overrun_Out   : sticky, a vector arrived while Ready_Out was low
// Optional (macro ARGMAX_STATS_EN):
//   Stat_Sel      : class counter to read
//   Stat_Clr      : synchronous clear of all class counters
//   Stat_Count    : selected 16-bit saturating win count
// -----------------------------------------------------------------------------
module argmax_classifier
#(
    parameter int                    DATA_WIDHT = 32,
    parameter int                    NUM_CLASS  = argmax_pkg::NUM_CLASS,
    parameter int                    IDX_WIDHT  = argmax_pkg::IDX_WIDHT,
    parameter logic [DATA_WIDHT-1:0] THRESHOLD  = argmax_pkg::THRESHOLD_DEF
)
(
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            Valid_In,
    output logic                            Ready_Out,
    input  logic [DATA_WIDHT*NUM_CLASS-1:0] Data_In,
    output logic                            Valid_Out,
    input  logic                            Ready_In,
    output logic [IDX_WIDHT-1:0]            Class_Out,
    output logic [DATA_WIDHT-1:0]           Score_Out,
    output logic                            Reject_Out,
    output logic                            Overrun_Out
`ifdef ARGMAX_STATS_EN
   ,input  logic [IDX_WIDHT-1:0]            Stat_Sel,
    input  logic                            Stat_Clr,
    output logic [15:0]                     Stat_Count
`endif
);
    import argmax_pkg::*;

    localparam logic [IDX_WIDHT-1:0] LAST_IDX  = IDX_WIDHT'(NUM_CLASS - 1);
    localparam logic [IDX_WIDHT-1:0] FIRST_CMP = IDX_WIDHT'(1);

    state_t                  state;
    logic [IDX_WIDHT-1:0]    cnt;
    logic [DATA_WIDHT-1:0]   vec [NUM_CLASS];
    logic [IDX_WIDHT-1:0]    best_idx;
    logic [DATA_WIDHT-1:0]   best_val;

    logic [DATA_WIDHT-1:0]   cand_val;
    logic                    cand_gt;
    logic                    scan_ge_unused;
    logic [DATA_WIDHT-1:0]   next_val;
    logic [IDX_WIDHT-1:0]    next_idx;
    logic                    thr_ge;
    logic                    thr_gt_unused;
    logic                    accept;
    logic                    handshake;

    assign Valid_Out = (state == ST_DONE);
    // In DONE the slot frees up in the same cycle the sink takes the result.
    assign Ready_Out = (state == ST_IDLE) || ((state == ST_DONE) && Ready_In);
    assign accept    = Valid_In && Ready_Out;
    assign handshake = Valid_Out && Ready_In;

    assign cand_val  = vec[cnt];

    fp32_cmp_ge u_scan_cmp (
        .a      (cand_val),
        .b      (best_val),
        .a_gt_b (cand_gt),
        .a_ge_b (scan_ge_unused)
    );

    // Strictly greater replaces, so ties stay with the lower index.
    assign next_val = cand_gt ? cand_val : best_val;
    assign next_idx = cand_gt ? cnt      : best_idx;

    // Threshold check runs on the post-compare best so the final class
    // gets its reject flag in the same cycle it is decided.
    fp32_cmp_ge u_thr_cmp (
        .a      (next_val),
        .b      (THRESHOLD),
        .a_gt_b (thr_gt_unused),
        .a_ge_b (thr_ge)
    );

    // Control path: FSM, scan counter, result registers, overrun flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            Class_Out   <= '0;
            Score_Out   <= '0;
            Reject_Out  <= 1'b0;
            Overrun_Out <= 1'b0;
        end else begin
            if (Valid_In && !Ready_Out)
                Overrun_Out <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (Valid_In) begin
                        state <= ST_SCAN;
                        cnt   <= FIRST_CMP;
                    end
                end
                ST_SCAN: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_IDX) begin
                        state      <= ST_DONE;
                        Class_Out  <= next_idx;
                        Score_Out  <= next_val;
                        Reject_Out <= !thr_ge;
                    end
                end
                ST_DONE: begin
                    if (Ready_In) begin
                        state <= Valid_In ? ST_SCAN : ST_IDLE;
                        cnt   <= FIRST_CMP;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Data path: captured vector and running best.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < NUM_CLASS; k++)
                vec[k] <= Data_In[DATA_WIDHT*k +: DATA_WIDHT];
            best_idx <= '0;
            best_val <= Data_In[DATA_WIDHT-1:0];
        end else if (state == ST_SCAN) begin
            best_idx <= next_idx;
            best_val <= next_val;
        end
    end

`ifdef ARGMAX_STATS_EN
    logic [15:0] stat_cnt [NUM_CLASS];

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst || Stat_Clr) begin
            for (int k = 0; k < NUM_CLASS; k++)
                stat_cnt[k] <= '0;
        end else if (handshake) begin
            for (int k = 0; k < NUM_CLASS; k++)
                if (Class_Out == IDX_WIDHT'(k))
                    stat_cnt[k] <= sat_inc16(stat_cnt[k]);
        end
    end

    always_comb begin
        Stat_Count = '0;
        for (int k = 0; k < NUM_CLASS; k++)
            if (Stat_Sel == IDX_WIDHT'(k))
                Stat_Count = stat_cnt[k];
    end
`else
    logic handshake_unused;
    assign handshake_unused = handshake;
`endif

endmodule

// File: tb/tb_argmax_classifier.sv
// -----------------------------------------------------------------------------
// tb_argmax_classifier
// Self-checking bench for argmax_classifier: directed cases plus randomized
// vectors checked against a real-valued reference model.
// -----------------------------------------------------------------------------
module tb_argmax_classifier;

    logic         clk;
    logic         rst;
    logic         Valid_In;
    logic         Ready_Out;
    logic [223:0] Data_In;
    logic         Valid_Out;
    logic         Ready_In;
    logic [2:0]   Class_Out;
    logic [31:0]  Score_Out;
    logic         Reject_Out;
    logic         Overrun_Out;
`ifdef ARGMAX_STATS_EN
    logic [2:0]   Stat_Sel;
    logic         Stat_Clr;
    logic [15:0]  Stat_Count;
`endif

    int n_checks = 0;
    int n_err    = 0;

    argmax_classifier dut (
        .clk         (clk),
        .rst         (rst),
        .Valid_In    (Valid_In),
        .Ready_Out   (Ready_Out),
        .Data_In     (Data_In),
        .Valid_Out   (Valid_Out),
        .Ready_In    (Ready_In),
        .Class_Out   (Class_Out),
        .Score_Out   (Score_Out),
        .Reject_Out  (Reject_Out),
        .Overrun_Out (Overrun_Out)
`ifdef ARGMAX_STATS_EN
       ,.Stat_Sel    (Stat_Sel),
        .Stat_Clr    (Stat_Clr),
        .Stat_Count  (Stat_Count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic is_nan(input logic [31:0] b);
        return (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    endfunction

    function automatic real fp_val(input logic [31:0] b);
        int  e;
        real r;
        e = int'(b[30:23]);
        r = real'(b[22:0]);
        if (e == 255) begin
            r = 1.0e300;
        end else begin
            if (e == 0) e = 1;
            else        r = r + 8388608.0;
            e = e - 150;
            while (e > 0) begin r = r * 2.0; e--; end
            while (e < 0) begin r = r / 2.0; e++; end
        end
        return b[31] ? -r : r;
    endfunction

    function automatic void model(input logic [223:0] d, output logic [2:0] idx,
                                  output logic [31:0] score, output logic rej);
        int          best;
        real         bv;
        logic [31:0] x;
        best = -1;
        bv   = 0.0;
        for (int k = 0; k < 7; k++) begin
            x = d[32*k +: 32];
            if (!is_nan(x) && (best < 0 || fp_val(x) > bv)) begin
                best = k;
                bv   = fp_val(x);
            end
        end
        if (best < 0) best = 0;
        idx   = 3'(best);
        score = d[32*best +: 32];
        rej   = is_nan(score) || !(bv >= 0.5);
    endfunction

    function automatic logic [31:0] rand_fp();
        case ($urandom_range(0, 7))
            0:       return $urandom();
            1:       return 32'h7FC00000;
            2:       return 32'h80000000;
            3:       return 32'h00000000;
            4:       return 32'h3F000000;
            default: return {1'b0, 8'd120 + 8'($urandom_range(0, 7)), 23'($urandom())};
        endcase
    endfunction

    function automatic logic [223:0] pack7(input logic [31:0] c0, input logic [31:0] c1,
                                           input logic [31:0] c2, input logic [31:0] c3,
                                           input logic [31:0] c4, input logic [31:0] c5,
                                           input logic [31:0] c6);
        return {c6, c5, c4, c3, c2, c1, c0};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        rst      = 1'b0;
        Valid_In = 1'b0;
        Ready_In = 1'b1;
        Data_In  = '0;
`ifdef ARGMAX_STATS_EN
        Stat_Sel = '0;
        Stat_Clr = 1'b0;
`endif
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Called with Valid_In just raised at a negedge; returns negedges to result.
    task automatic wait_result(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            Valid_In = 1'b0;
            lat++;
        end while (!Valid_Out && lat < 30);
    endtask

    task automatic run_vec(input logic [223:0] d, input string tag);
        logic [2:0]  ei;
        logic [31:0] es;
        logic        er;
        int          lat;
        int          w;
        model(d, ei, es, er);
        w = 0;
        while (!Ready_Out && w < 40) begin @(negedge clk); w++; end
        Valid_In = 1'b1;
        Data_In  = d;
        wait_result(lat);
        check_eq({tag, "_latency"}, lat, 7);
        check_eq({tag, "_class"}, {29'd0, Class_Out}, {29'd0, ei});
        check_eq({tag, "_score"}, Score_Out, es);
        check_eq({tag, "_reject"}, {31'd0, Reject_Out}, {31'd0, er});
        @(negedge clk);
        check_eq({tag, "_valid_drop"}, {31'd0, Valid_Out}, 32'd0);
    endtask

    localparam logic [31:0] F005 = 32'h3D4CCCCD;
    localparam logic [31:0] F010 = 32'h3DCCCCCD;
    localparam logic [31:0] F030 = 32'h3E99999A;
    localparam logic [31:0] F060 = 32'h3F19999A;
    localparam logic [31:0] F090 = 32'h3F666666;
    localparam logic [31:0] FM1  = 32'hBF800000;
    localparam logic [31:0] QNAN = 32'h7FC00000;

    initial begin
        logic [223:0] va;
        logic [223:0] vb;
        logic [2:0]   cap_cls;
        logic [31:0]  cap_score;
        logic         cap_rej;
        logic         stable;
        logic         seen;
        int           lat;

        do_reset();
        @(negedge clk);
        check_eq("rst_valid",   {31'd0, Valid_Out},   32'd0);
        check_eq("rst_ready",   {31'd0, Ready_Out},   32'd1);
        check_eq("rst_class",   {29'd0, Class_Out},   32'd0);
        check_eq("rst_score",   Score_Out,            32'd0);
        check_eq("rst_reject",  {31'd0, Reject_Out},  32'd0);
        check_eq("rst_overrun", {31'd0, Overrun_Out}, 32'd0);

        // Clear winner
        va = pack7(F005, F010, F060, F005, F010, F005, F005);
        run_vec(va, "single");
        check_eq("single_class_const", {29'd0, Class_Out}, 32'd2);
        check_eq("single_score_const", Score_Out, 32'h3F19999A);

        // Tie keeps lower index, low confidence
        run_vec(pack7(F030, F010, F030, F010, F010, F005, F005), "tie");
        check_eq("tie_class_const",  {29'd0, Class_Out},  32'd0);
        check_eq("tie_reject_const", {31'd0, Reject_Out}, 32'd1);

        // Sink stall with a dropped vector
        Ready_In = 1'b0;
        Valid_In = 1'b1;
        Data_In  = va;
        wait_result(lat);
        check_eq("stall_latency", lat, 7);
        cap_cls   = Class_Out;
        cap_score = Score_Out;
        cap_rej   = Reject_Out;
        stable    = 1'b1;
        for (int i = 0; i < 20; i++) begin
            Valid_In = (i == 5);
            Data_In  = pack7(F090, F010, F010, F010, F010, F010, F010);
            @(negedge clk);
            if (!Valid_Out || Class_Out !== cap_cls || Score_Out !== cap_score || Reject_Out !== cap_rej)
                stable = 1'b0;
        end
        Valid_In = 1'b0;
        check_eq("stall_stable",  {31'd0, stable},      32'd1);
        check_eq("stall_class",   {29'd0, cap_cls},     32'd2);
        check_eq("stall_overrun", {31'd0, Overrun_Out}, 32'd1);
        Ready_In = 1'b1;
        @(negedge clk);
        check_eq("stall_release_valid", {31'd0, Valid_Out}, 32'd0);
        check_eq("stall_release_ready", {31'd0, Ready_Out}, 32'd1);
        check_eq("stall_release_hold",  Score_Out, cap_score);

        do_reset();
        @(negedge clk);
        check_eq("overrun_cleared", {31'd0, Overrun_Out}, 32'd0);

        // Back-to-back: new vector accepted on the handshake edge
        vb = pack7(F010, F010, F010, F010, F010, F090, F010);
        Valid_In = 1'b1;
        Data_In  = va;
        wait_result(lat);
        check_eq("b2b_first_latency", lat, 7);
        check_eq("b2b_first_class", {29'd0, Class_Out}, 32'd2);
        Valid_In = 1'b1;
        Data_In  = vb;
        wait_result(lat);
        check_eq("b2b_second_latency", lat, 7);
        check_eq("b2b_second_class", {29'd0, Class_Out}, 32'd5);
        check_eq("b2b_overrun", {31'd0, Overrun_Out}, 32'd0);
        @(negedge clk);

        // NaN handling
        run_vec(pack7(FM1, F010, F010, F010, F010, F010, QNAN), "nan6");
        check_eq("nan6_class_const", {29'd0, Class_Out}, 32'd1);
        run_vec(pack7(32'h7FC00001, QNAN, 32'hFFC00000, QNAN, 32'h7F800001, QNAN, QNAN), "allnan");
        check_eq("allnan_class_const",  {29'd0, Class_Out},  32'd0);
        check_eq("allnan_reject_const", {31'd0, Reject_Out}, 32'd1);
        // Signed zeros tie, later positive below threshold loses to nothing
        run_vec(pack7(32'h80000000, 32'h00000000, FM1, 32'h80000000, FM1, FM1, FM1), "zeros");

        // Reset in the middle of a scan
        Valid_In = 1'b1;
        Data_In  = va;
        @(negedge clk);
        Valid_In = 1'b0;
        @(negedge clk);
        Valid_In = 1'b1;
        @(negedge clk);
        Valid_In = 1'b0;
        check_eq("midscan_overrun_set", {31'd0, Overrun_Out}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check_eq("midscan_valid",   {31'd0, Valid_Out},   32'd0);
        check_eq("midscan_ready",   {31'd0, Ready_Out},   32'd1);
        check_eq("midscan_overrun", {31'd0, Overrun_Out}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (Valid_Out) seen = 1'b1;
        end
        check_eq("midscan_no_result", {31'd0, seen}, 32'd0);

        // Randomized vectors
        for (int n = 0; n < 40; n++) begin
            logic [223:0] rv;
            for (int k = 0; k < 7; k++)
                rv[32*k +: 32] = rand_fp();
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_vec(rv, $sformatf("rand%0d", n));
        end

`ifdef ARGMAX_STATS_EN
        do_reset();
        @(negedge clk);
        for (int n = 0; n < 3; n++)
            run_vec(pack7(F010, F010, F010, F010, F090, F010, F010), "stat_vec");
        run_vec(va, "stat_other");
        Stat_Sel = 3'd4;
        #1;
        check_eq("stat_class4", {16'd0, Stat_Count}, 32'd3);
        Stat_Sel = 3'd2;
        #1;
        check_eq("stat_class2", {16'd0, Stat_Count}, 32'd1);
        Stat_Sel = 3'd7;
        #1;
        check_eq("stat_out_of_range", {16'd0, Stat_Count}, 32'd0);
        @(negedge clk);
        Stat_Clr = 1'b1;
        @(negedge clk);
        Stat_Clr = 1'b0;
        Stat_Sel = 3'd4;
        #1;
        check_eq("stat_cleared", {16'd0, Stat_Count}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
